// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit path. Byte FIFO feeding an 8N1 serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLOCK_DIVIDE = 271,
    parameter int ADDR_EXP     = 4,
    parameter int ADDR_DEPTH   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          tx_byte,
    input  logic                transmit,
    output logic                tx_fifo_full,
    output logic                tx_fifo_empty,
    output logic [ADDR_EXP:0]   tx_fifo_count,
    output logic                busy,
    output logic                tx
);

    localparam int                c_baud_w    = $clog2(CLOCK_DIVIDE);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLOCK_DIVIDE - 1);
    localparam logic [ADDR_EXP:0] c_depth     = (ADDR_EXP + 1)'(ADDR_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_baud_w-1:0]  r_baud;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_busy;

    logic [7:0]           r_mem [ADDR_DEPTH];
    logic [ADDR_EXP:0]    r_wr_ptr;
    logic [ADDR_EXP:0]    r_rd_ptr;
    logic                 r_full;
    logic                 r_empty;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic [ADDR_EXP:0]    w_wr_next;
    logic [ADDR_EXP:0]    w_rd_next;
    logic [ADDR_EXP:0]    w_count_next;

    // The registered full flag alone gates pushes, so a same-edge pop never frees a slot early.
    assign w_push       = transmit && !r_full;
    assign w_pop        = (r_state == ST_IDLE) && !r_empty;
    assign w_bit_end    = (r_baud == c_baud_last);
    assign w_wr_next    = r_wr_ptr + (ADDR_EXP + 1)'(w_push);
    assign w_rd_next    = r_rd_ptr + (ADDR_EXP + 1)'(w_pop);
    assign w_count_next = w_wr_next - w_rd_next;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_EXP-1:0]] <= tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_full   <= (w_count_next == c_depth);
            r_empty  <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr[ADDR_EXP-1:0]];
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_fifo_full  = r_full;
    assign tx_fifo_empty = r_empty;
    assign tx_fifo_count = r_wr_ptr - r_rd_ptr;
    assign busy          = r_busy;
    assign tx            = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Directed and random stimulus against a frame-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int CD = 4;
    localparam int AE = 4;
    localparam int AD = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          transmit = 1'b0;
    logic [7:0]    tx_byte = 8'h00;
    logic          tx_fifo_full;
    logic          tx_fifo_empty;
    logic [AE:0]   tx_fifo_count;
    logic          busy;
    logic          tx;

    uart_tx_serializer #(
        .CLOCK_DIVIDE (CD),
        .ADDR_EXP     (AE),
        .ADDR_DEPTH   (AD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .tx_byte       (tx_byte),
        .transmit      (transmit),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_count (tx_fifo_count),
        .busy          (busy),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference: pending bytes, byte on the line, and cycles since its start bit began (-1 = idle).
    logic [7:0]  q[$];
    logic [7:0]  cur = 8'h00;
    int          fpos = -1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (fpos < 0) return 1'b1;
        k = fpos / CD;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic t, input logic [7:0] b, input logic rn);
        logic can_push;
        logic do_pop;
        if (!rn) begin
            q.delete();
            fpos = -1;
            return;
        end
        can_push = t && (q.size() < AD);
        do_pop   = (fpos < 0) && (q.size() > 0);
        if (fpos >= 0) begin
            fpos++;
            if (fpos == 10 * CD) fpos = -1;
        end
        if (do_pop) begin
            cur  = q.pop_front();
            fpos = 0;
        end
        if (can_push) q.push_back(b);
    endtask

    task automatic cycle(input logic t, input logic [7:0] b, input logic rn);
        transmit = t;
        tx_byte  = b;
        resetn   = rn;
        @(posedge clk);
        model_edge(t, b, rn);
        #1;
        check_value("tx",    32'(tx),            32'(exp_tx()));
        check_value("busy",  32'(busy),          32'(fpos >= 0));
        check_value("count", 32'(tx_fifo_count), 32'(q.size()));
        check_value("full",  32'(tx_fifo_full),  32'(q.size() == AD));
        check_value("empty", 32'(tx_fifo_empty), 32'(q.size() == 0));
    endtask

    task automatic drain(input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (fpos < 0 && q.size() == 0) begin
                done = 1'b1;
                break;
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        check_value("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic found;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        check_value("rst_tx", 32'(tx), 32'd1);
        check_value("rst_count", 32'(tx_fifo_count), 32'd0);

        // Single byte: start bit appears on the edge after the strobe
        cycle(1'b1, 8'h55, 1'b1);
        check_value("single_tx_before_start", 32'(tx), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check_value("single_start_bit", 32'(tx), 32'd0);
        drain(100);

        // Two back-to-back frames
        cycle(1'b1, 8'hA5, 1'b1);
        cycle(1'b1, 8'h3C, 1'b1);
        drain(200);

        // Overfill: 17 pushes leave 16 queued, the 18th is dropped
        for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1);
        check_value("overfill_full",  32'(tx_fifo_full),  32'd1);
        check_value("overfill_count", 32'(tx_fifo_count), 32'd16);
        cycle(1'b1, 8'hFF, 1'b1);
        check_value("drop_count", 32'(tx_fifo_count), 32'd16);
        drain(17 * (10 * CD + 1) + 50);

        // Push coincident with an idle pop while one byte is queued
        cycle(1'b1, 8'h11, 1'b1);
        cycle(1'b1, 8'h22, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fpos < 0 && q.size() == 1) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        check_value("idle_one_reached", 32'(found), 32'd1);
        cycle(1'b1, 8'h77, 1'b1);
        check_value("pushpop_count", 32'(tx_fifo_count), 32'd1);
        drain(200);

        // Reset mid-frame during data bit 3 with five bytes queued
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fpos >= 0 && fpos / CD == 4) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        check_value("bit3_reached", 32'(found), 32'd1);
        check_value("bit3_queued", 32'(tx_fifo_count), 32'd5);
        cycle(1'b0, 8'h00, 1'b0);
        check_value("abort_tx",    32'(tx),            32'd1);
        check_value("abort_count", 32'(tx_fifo_count), 32'd0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            check_value("post_abort_idle", 32'(tx), 32'd1);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 599) != 0));
        end
        drain(AD * (10 * CD + 1) + 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
